// File: rtl/ad9866_gain_sequencer.sv
// Turns RX/TX gain inputs into one-at-a-time SPI write requests for the AD9866 controller.
// Each input must be stable before it is written; requests are spaced out and retried if never acknowledged.
module ad9866_gain_sequencer #(
   parameter int STABLE_CYCLES  = 16,
   parameter int GAP_CYCLES     = 4,
   parameter int TIMEOUT_CYCLES = 64,
   parameter int INIT_HOLDOFF   = 1024
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] rx_gain_in,
   input  logic [5:0] tx_gain_in,
   input  logic       ptt,
   input  logic       sen_n,
   output logic       rx_rqst,
   output logic [5:0] rx_gain,
   output logic       tx_rqst,
   output logic [5:0] tx_gain,
   output logic       busy,
   output logic       timeout_err
);

   localparam logic [15:0] STABLE_MAX   = 16'(STABLE_CYCLES);
   localparam logic [15:0] STABLE_LAST  = 16'(STABLE_CYCLES - 1);
   localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
   localparam logic [15:0] HOLDOFF_LAST = 16'(INIT_HOLDOFF - 1);
   localparam logic [15:0] GAP_LAST     = 16'(GAP_CYCLES - 1);
   localparam bit          GAP_NONE     = (GAP_CYCLES == 0);

   typedef enum logic [2:0] {HOLDOFF, IDLE, REQ, BUSY, GAP} state_t;

   logic [5:0]  rx_cand_q, rx_cand_d, tx_cand_q, tx_cand_d;
   logic [15:0] rx_cnt_q, rx_cnt_d, tx_cnt_q, tx_cnt_d;
   logic        rx_set, tx_set;

   state_t      state_q;
   logic [15:0] timer_q;
   logic        sel_tx_q;
   logic        rx_pend_q, tx_pend_q;
   logic [5:0]  rx_target_q, tx_target_q;
   logic [5:0]  rx_gain_q, tx_gain_q;
   logic        rx_rqst_q, tx_rqst_q;
   logic        busy_q, timeout_err_q;

   // Stability filter: cand tracks the input, the counter measures how long it has held.
   always_comb begin
      rx_cand_d = rx_gain_in;
      rx_cnt_d  = rx_cnt_q;
      if (rx_gain_in != rx_cand_q)
         rx_cnt_d = '0;
      else if (rx_cnt_q != STABLE_MAX)
         rx_cnt_d = rx_cnt_q + 16'd1;

      tx_cand_d = tx_gain_in;
      tx_cnt_d  = tx_cnt_q;
      if (tx_gain_in != tx_cand_q)
         tx_cnt_d = '0;
      else if (tx_cnt_q != STABLE_MAX)
         tx_cnt_d = tx_cnt_q + 16'd1;
   end

   assign rx_set = (rx_gain_in == rx_cand_q) && (rx_cnt_q == STABLE_LAST) && (rx_cand_q != rx_target_q);
   assign tx_set = (tx_gain_in == tx_cand_q) && (tx_cnt_q == STABLE_LAST) && (tx_cand_q != tx_target_q);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_cand_q <= '0;
         tx_cand_q <= '0;
         rx_cnt_q  <= '0;
         tx_cnt_q  <= '0;
      end else begin
         rx_cand_q <= rx_cand_d;
         tx_cand_q <= tx_cand_d;
         rx_cnt_q  <= rx_cnt_d;
         tx_cnt_q  <= tx_cnt_d;
      end
   end

   // A launch clears its own pending flag after the filter's set, so the later assignment wins;
   // that is safe because the launched value is exactly the cand that would have set it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= HOLDOFF;
         timer_q       <= '0;
         sel_tx_q      <= 1'b0;
         rx_pend_q     <= 1'b0;
         tx_pend_q     <= 1'b0;
         rx_target_q   <= '0;
         tx_target_q   <= '0;
         rx_gain_q     <= '0;
         tx_gain_q     <= '0;
         rx_rqst_q     <= 1'b0;
         tx_rqst_q     <= 1'b0;
         busy_q        <= 1'b1;
         timeout_err_q <= 1'b0;
      end else begin
         if (rx_set) rx_pend_q <= 1'b1;
         if (tx_set) tx_pend_q <= 1'b1;

         case (state_q)
            HOLDOFF: begin
               if (timer_q == HOLDOFF_LAST) begin
                  rx_pend_q <= 1'b1;
                  tx_pend_q <= 1'b1;
                  timer_q   <= '0;
                  state_q   <= IDLE;
                  busy_q    <= 1'b0;
               end else begin
                  timer_q <= timer_q + 16'd1;
               end
            end
            IDLE: begin
               if (rx_pend_q || tx_pend_q) begin
                  state_q <= REQ;
                  timer_q <= '0;
                  busy_q  <= 1'b1;
                  if (tx_pend_q && (ptt || !rx_pend_q)) begin
                     sel_tx_q    <= 1'b1;
                     tx_gain_q   <= tx_cand_q;
                     tx_target_q <= tx_cand_q;
                     tx_pend_q   <= 1'b0;
                     tx_rqst_q   <= 1'b1;
                  end else begin
                     sel_tx_q    <= 1'b0;
                     rx_gain_q   <= rx_cand_q;
                     rx_target_q <= rx_cand_q;
                     rx_pend_q   <= 1'b0;
                     rx_rqst_q   <= 1'b1;
                  end
               end
            end
            REQ: begin
               if (!sen_n) begin
                  rx_rqst_q <= 1'b0;
                  tx_rqst_q <= 1'b0;
                  state_q   <= BUSY;
               end else if (timer_q == TIMEOUT_LAST) begin
                  rx_rqst_q     <= 1'b0;
                  tx_rqst_q     <= 1'b0;
                  timeout_err_q <= 1'b1;
                  if (sel_tx_q) tx_pend_q <= 1'b1;
                  else          rx_pend_q <= 1'b1;
                  timer_q <= '0;
                  state_q <= GAP;
               end else begin
                  timer_q <= timer_q + 16'd1;
               end
            end
            BUSY: begin
               if (sen_n) begin
                  timer_q <= '0;
                  state_q <= GAP;
               end
            end
            GAP: begin
               if (GAP_NONE || timer_q == GAP_LAST) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end else begin
                  timer_q <= timer_q + 16'd1;
               end
            end
            default: begin
               state_q   <= HOLDOFF;
               timer_q   <= '0;
               rx_rqst_q <= 1'b0;
               tx_rqst_q <= 1'b0;
               busy_q    <= 1'b1;
            end
         endcase
      end
   end

   assign rx_rqst     = rx_rqst_q;
   assign tx_rqst     = tx_rqst_q;
   assign rx_gain     = rx_gain_q;
   assign tx_gain     = tx_gain_q;
   assign busy        = busy_q;
   assign timeout_err = timeout_err_q;

endmodule
